// File: rtl/pfixed_to_pfloat.sv
// Signed fixed-point (P / 2^FRAC) to IEEE-754 single-precision converter.
// Iterative normaliser: one left shift per clock, truncating mantissa, Begin/ACK handshake.
module pfixed_to_pfloat #(
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 16
) (
  input  logic         CLK,
  input  logic         RST_FF,
  input  logic         RST_FSM_FF,
  input  logic         Begin_FSM_FF,
  input  logic [W-1:0] P,
  output logic         ACK_FF,
  output logic [31:0]  RESULT
);

  localparam int unsigned KW      = $clog2(W);
  localparam int          ExpBias = 127 + int'(W) - 1 - int'(FRAC);

  typedef enum logic [2:0] {StIdle, StAbs, StNorm, StPack, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    op_q, op_d;
  logic            sgn_q, sgn_d;
  logic [W-1:0]    mag_q, mag_d;
  logic [KW-1:0]   k_q, k_d;
  logic [31:0]     result_q, result_d;
  logic [7:0]      exp_w;

  // Exponent arithmetic is modulo 256; legal parameters keep it within 1..254.
  assign exp_w = 8'(ExpBias) - 8'(k_q);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sgn_d    = sgn_q;
    mag_d    = mag_q;
    k_d      = k_q;
    result_d = result_q;
    if (RST_FSM_FF) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Begin_FSM_FF) begin
            op_d    = P;
            state_d = StAbs;
          end
        end
        StAbs: begin
          sgn_d   = op_q[W-1];
          // W-bit wrap makes the most negative value map to 2^(W-1).
          mag_d   = op_q[W-1] ? (~op_q + W'(1)) : op_q;
          k_d     = '0;
          state_d = (op_q == '0) ? StPack : StNorm;
        end
        StNorm: begin
          if (mag_q[W-1]) begin
            state_d = StPack;
          end else begin
            mag_d = mag_q << 1;
            k_d   = k_q + KW'(1);
          end
        end
        StPack: begin
          if (mag_q == '0) begin
            result_d = 32'h0000_0000;
          end else begin
            result_d = {sgn_q, exp_w, mag_q[W-2:W-24]};
          end
          state_d = StDone;
        end
        StDone: begin
          state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST_FF) begin
    if (RST_FF) begin
      state_q  <= StIdle;
      op_q     <= '0;
      sgn_q    <= 1'b0;
      mag_q    <= '0;
      k_q      <= '0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sgn_q    <= sgn_d;
      mag_q    <= mag_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

  assign ACK_FF = (state_q == StDone);
  assign RESULT = result_q;

endmodule
